// File: rtl/line_check_if.sv
// line_check_if: segment-programming, pixel and result signals of line_check_pipe
interface line_check_if #(
    parameter int COORD_W = 21,
    parameter int NUM_SEG = 4,
    parameter int CNT_W   = 20,
    parameter int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
);
    logic                      seg_wr_en;
    logic [IDX_W-1:0]          seg_wr_idx;
    logic                      seg_wr_ena;
    logic signed [COORD_W-1:0] seg_ax, seg_ay, seg_bx, seg_by;
    logic                      pix_valid;
    logic signed [COORD_W-1:0] h_cnt_Q, v_cnt_Q;
    logic                      frame_start;
    logic                      out_valid;
    logic [NUM_SEG-1:0]        on_line_mask;
    logic                      on_line;
    logic [IDX_W-1:0]          hit_idx;
    logic [CNT_W-1:0]          hit_cnt;
    modport master (
        output seg_wr_en, seg_wr_idx, seg_wr_ena, seg_ax, seg_ay, seg_bx, seg_by,
        output pix_valid, h_cnt_Q, v_cnt_Q, frame_start,
        input  out_valid, on_line_mask, on_line, hit_idx, hit_cnt
    );
    modport slave (
        input  seg_wr_en, seg_wr_idx, seg_wr_ena, seg_ax, seg_ay, seg_bx, seg_by,
        input  pix_valid, h_cnt_Q, v_cnt_Q, frame_start,
        output out_valid, on_line_mask, on_line, hit_idx, hit_cnt
    );
endinterface

// File: rtl/line_check_pipe.sv
// line_check_pipe: 3-stage point-on-segment tester over NUM_SEG programmable slots
module line_check_pipe #(
    parameter int COORD_W = 21,
    parameter int FRAC_W  = 10,
    parameter int NUM_SEG = 4,
    parameter int TH      = 1024,
    parameter int CNT_W   = 20,
    parameter int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input logic         clk,
    input logic         rst,
    line_check_if.slave bus
);
    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * COORD_W + 2;
    localparam logic signed [PW-1:0] THW = PW'(TH);

    function automatic logic signed [DW-1:0] ext(input logic signed [COORD_W-1:0] v);
        return {v[COORD_W-1], v};
    endfunction

    logic                      en_q [NUM_SEG];
    logic signed [COORD_W-1:0] ax_q [NUM_SEG], ay_q [NUM_SEG], bx_q [NUM_SEG], by_q [NUM_SEG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                en_q[i] <= 1'b0;
                ax_q[i] <= '0;
                ay_q[i] <= '0;
                bx_q[i] <= '0;
                by_q[i] <= '0;
            end
        end else if (bus.seg_wr_en) begin
            en_q[bus.seg_wr_idx] <= bus.seg_wr_ena;
            ax_q[bus.seg_wr_idx] <= bus.seg_ax;
            ay_q[bus.seg_wr_idx] <= bus.seg_ay;
            bx_q[bus.seg_wr_idx] <= bus.seg_bx;
            by_q[bus.seg_wr_idx] <= bus.seg_by;
        end
    end

    logic signed [DW-1:0] apx_d [NUM_SEG], apy_d [NUM_SEG], abx_d [NUM_SEG], aby_d [NUM_SEG];
    logic                 bb_d [NUM_SEG];

    always_comb begin
        for (int i = 0; i < NUM_SEG; i++) begin
            apx_d[i] = ext(bus.h_cnt_Q) - ext(ax_q[i]);
            apy_d[i] = ext(bus.v_cnt_Q) - ext(ay_q[i]);
            abx_d[i] = ext(bx_q[i]) - ext(ax_q[i]);
            aby_d[i] = ext(by_q[i]) - ext(ay_q[i]);
            bb_d[i]  = (bus.h_cnt_Q >= ((ax_q[i] < bx_q[i]) ? ax_q[i] : bx_q[i])) &&
                       (bus.h_cnt_Q <= ((ax_q[i] < bx_q[i]) ? bx_q[i] : ax_q[i])) &&
                       (bus.v_cnt_Q >= ((ay_q[i] < by_q[i]) ? ay_q[i] : by_q[i])) &&
                       (bus.v_cnt_Q <= ((ay_q[i] < by_q[i]) ? by_q[i] : ay_q[i]));
        end
    end

    logic                 v1_q, v2_q;
    logic signed [DW-1:0] apx_q [NUM_SEG], apy_q [NUM_SEG], abx_q [NUM_SEG], aby_q [NUM_SEG];
    logic                 bb1_q [NUM_SEG], en1_q [NUM_SEG], bb2_q [NUM_SEG], en2_q [NUM_SEG];
    logic signed [PW-1:0] p1_q [NUM_SEG], p2_q [NUM_SEG];

    // Datapath registers carry no reset; every result they feed is gated by a valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SEG; i++) begin
            apx_q[i] <= apx_d[i];
            apy_q[i] <= apy_d[i];
            abx_q[i] <= abx_d[i];
            aby_q[i] <= aby_d[i];
            bb1_q[i] <= bb_d[i];
            en1_q[i] <= en_q[i];
            p1_q[i]  <= PW'(abx_q[i]) * PW'(apy_q[i]);
            p2_q[i]  <= PW'(apx_q[i]) * PW'(aby_q[i]);
            bb2_q[i] <= bb1_q[i];
            en2_q[i] <= en1_q[i];
        end
    end

    logic signed [PW-1:0] cross_d [NUM_SEG];
    logic [NUM_SEG-1:0]   hit_d;
    logic [IDX_W-1:0]     idx_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 ov_q, on_q;
    logic [NUM_SEG-1:0]   mask_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_W-1:0]     cnt_q;

    always_comb begin
        hit_d = '0;
        idx_d = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            cross_d[i] = (p1_q[i] - p2_q[i]) >>> FRAC_W;
            hit_d[i]   = v2_q && en2_q[i] && bb2_q[i] && (cross_d[i] > -THW) && (cross_d[i] < THW);
        end
        for (int i = NUM_SEG - 1; i >= 0; i--) idx_d = hit_d[i] ? IDX_W'(i) : idx_d;
        cnt_d = bus.frame_start ? CNT_W'(ov_q && on_q) :
                (ov_q && on_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            ov_q   <= 1'b0;
            mask_q <= '0;
            on_q   <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= bus.pix_valid;
            v2_q   <= v1_q;
            ov_q   <= v2_q;
            mask_q <= hit_d;
            on_q   <= |hit_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.out_valid    = ov_q;
    assign bus.on_line_mask = mask_q;
    assign bus.on_line      = on_q;
    assign bus.hit_idx      = idx_q;
    assign bus.hit_cnt      = cnt_q;
endmodule

// File: tb/tb_line_check_pipe.sv
// tb_line_check_pipe: directed literal checks plus randomized run against a geometric model
module tb_line_check_pipe;
    localparam int NS   = 4;
    localparam int CW   = 21;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_check_if #(.COORD_W(CW), .NUM_SEG(NS), .CNT_W(CNTW)) bus ();
    line_check_pipe #(.COORD_W(CW), .FRAC_W(10), .NUM_SEG(NS), .TH(1024), .CNT_W(CNTW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    bit     m_en [NS];
    longint m_ax [NS], m_ay [NS], m_bx [NS], m_by [NS];
    bit          pv [3];
    logic [NS-1:0] pm [3];
    int     ecnt;

    // Point is on segment i when inside its box and |cross/1024| stays under one pixel.
    function automatic logic [NS-1:0] eval(input longint px, input longint py);
        logic [NS-1:0] r = '0;
        longint cr;
        for (int i = 0; i < NS; i++) begin
            cr = ((m_bx[i] - m_ax[i]) * (py - m_ay[i]) - (px - m_ax[i]) * (m_by[i] - m_ay[i])) >>> 10;
            r[i] = m_en[i] &&
                   px >= ((m_ax[i] < m_bx[i]) ? m_ax[i] : m_bx[i]) && px <= ((m_ax[i] > m_bx[i]) ? m_ax[i] : m_bx[i]) &&
                   py >= ((m_ay[i] < m_by[i]) ? m_ay[i] : m_by[i]) && py <= ((m_ay[i] > m_by[i]) ? m_ay[i] : m_by[i]) &&
                   cr > -1024 && cr < 1024;
        end
        return r;
    endfunction

    function automatic int lowest(input logic [NS-1:0] m);
        for (int i = 0; i < NS; i++) if (m[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_en[i] = 0; m_ax[i] = 0; m_ay[i] = 0; m_bx[i] = 0; m_by[i] = 0;
            end
            for (int i = 0; i < 3; i++) begin pv[i] = 0; pm[i] = '0; end
            ecnt = 0;
        end else begin
            if (bus.frame_start) ecnt = (pv[2] && pm[2] != 0) ? 1 : 0;
            else if (pv[2] && pm[2] != 0 && ecnt < CMAX) ecnt++;
            pv[2] = pv[1]; pm[2] = pm[1];
            pv[1] = pv[0]; pm[1] = pm[0];
            pv[0] = bus.pix_valid;
            pm[0] = bus.pix_valid ? eval(bus.h_cnt_Q, bus.v_cnt_Q) : '0;
            if (bus.seg_wr_en) begin
                m_en[bus.seg_wr_idx] = bus.seg_wr_ena;
                m_ax[bus.seg_wr_idx] = bus.seg_ax;
                m_ay[bus.seg_wr_idx] = bus.seg_ay;
                m_bx[bus.seg_wr_idx] = bus.seg_bx;
                m_by[bus.seg_wr_idx] = bus.seg_by;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] got, exp;
        if (chk_en) begin
            exp = {pv[2], pm[2], pm[2] != 0, 2'(lowest(pm[2])), 4'(ecnt)};
            got = {bus.out_valid, bus.on_line_mask, bus.on_line, bus.hit_idx, bus.hit_cnt};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL model t=%0t {ov,mask,on,idx,cnt} got=%h exp=%h", $time, got, exp);
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seg(input int idx, input int en, input int ax, input int ay, input int bx, input int by);
        bus.seg_wr_en = 1; bus.seg_wr_idx = 2'(idx); bus.seg_wr_ena = en[0];
        bus.seg_ax = CW'(ax); bus.seg_ay = CW'(ay); bus.seg_bx = CW'(bx); bus.seg_by = CW'(by);
    endtask

    task automatic wr(input int idx, input int en, input int ax, input int ay, input int bx, input int by);
        set_seg(idx, en, ax, ay, bx, by);
        tick();
        bus.seg_wr_en = 0;
    endtask

    task automatic pix(input int x, input int y);
        bus.pix_valid = 1; bus.h_cnt_Q = CW'(x); bus.v_cnt_Q = CW'(y);
        tick();
        bus.pix_valid = 0;
        tick();
        tick();
    endtask

    int vp [10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
    int hp [10] = '{1, 1, 0, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        longint px, py;
        int s, big;
        rst = 1;
        bus.seg_wr_en = 0; bus.seg_wr_idx = 0; bus.seg_wr_ena = 0;
        bus.seg_ax = 0; bus.seg_ay = 0; bus.seg_bx = 0; bus.seg_by = 0;
        bus.pix_valid = 0; bus.h_cnt_Q = 0; bus.v_cnt_Q = 0; bus.frame_start = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_mask", bus.on_line_mask, 0);
        chk("rst_cnt", bus.hit_cnt, 0);

        wr(0, 1, 0, 0, 'h2800, 'h2800);
        pix('h1400, 'h1400);
        chk("t1_ov", bus.out_valid, 1);
        chk("t1_mask", bus.on_line_mask, 4'b0001);
        chk("t1_idx", bus.hit_idx, 0);
        pix('h1400, 'h1800);
        chk("t2_far", bus.on_line, 0);
        pix('h1400, 'h1400 + 102);
        chk("t2_in", bus.on_line_mask, 4'b0001);
        pix('h1400, 'h1400 + 103);
        chk("t2_out", bus.on_line, 0);
        pix('h3000, 'h3000);
        chk("t3_bbox", bus.on_line, 0);
        pix('h2800, 'h2800);
        chk("t3_end", bus.on_line_mask, 4'b0001);

        wr(0, 0, 0, 0, 0, 0);
        wr(1, 1, 0, 0, 'h2800, 'h2800);
        wr(2, 1, 'h1000, 'h1000, 'h2000, 'h2000);
        pix('h1400, 'h1400);
        chk("t4_mask", bus.on_line_mask, 4'b0110);
        chk("t4_idx", bus.hit_idx, 1);
        set_seg(1, 1, 'h100, 'h100, 'h100, 'h100);
        pix('h1400, 'h1400);
        bus.seg_wr_en = 0;
        chk("t4_old", bus.on_line_mask, 4'b0110);
        pix('h1400, 'h1400);
        chk("t4_new", bus.on_line_mask, 4'b0100);
        chk("t4_nidx", bus.hit_idx, 2);

        tick(); tick();
        bus.frame_start = 1;
        tick();
        bus.frame_start = 0;
        for (int k = 0; k < 12; k++) begin
            bus.pix_valid = (k < 10) ? vp[k][0] : 1'b0;
            bus.h_cnt_Q = (k < 10 && hp[k] == 0) ? CW'('h1400) : CW'('h1800);
            bus.v_cnt_Q = CW'('h1800);
            tick();
            if (k >= 2) begin
                chk("t5_ov", bus.out_valid, vp[k-2]);
                chk("t5_on", bus.on_line, hp[k-2]);
            end
        end
        bus.pix_valid = 0;
        tick();
        chk("t5_cnt", bus.hit_cnt, 5);
        bus.pix_valid = 1; bus.h_cnt_Q = CW'('h1800); bus.v_cnt_Q = CW'('h1800);
        tick();
        bus.pix_valid = 0;
        tick(); tick();
        bus.frame_start = 1;
        tick();
        bus.frame_start = 0;
        chk("t5_fs", bus.hit_cnt, 1);

        big = 'h0FFC00;
        wr(1, 0, 0, 0, 0, 0);
        wr(2, 0, 0, 0, 0, 0);
        wr(3, 1, -big, -big, big, big);
        pix('h80000, 'h80000);
        chk("t6_mid", bus.on_line_mask, 4'b1000);
        chk("t6_idx", bus.hit_idx, 3);
        pix(-big, -big);
        chk("t6_a", bus.on_line_mask, 4'b1000);
        pix(big, -big);
        chk("t6_off", bus.on_line, 0);
        chk("t6_offv", bus.out_valid, 1);

        for (int k = 0; k < 4; k++) begin
            bus.pix_valid = 1; bus.h_cnt_Q = CW'('h1000); bus.v_cnt_Q = CW'('h1000);
            tick();
        end
        bus.pix_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 3; k++) chk("t6_rst", bus.out_valid, 0);
        tick();
        chk("t6_rst1", bus.out_valid, 0);
        tick();
        chk("t6_rst2", bus.out_valid, 0);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.frame_start = ($urandom_range(0, 39) == 0);
            bus.seg_wr_en = ($urandom_range(0, 9) == 0);
            bus.seg_wr_idx = 2'($urandom_range(0, NS - 1));
            bus.seg_wr_ena = ($urandom_range(0, 3) != 0);
            bus.seg_ax = CW'(int'($urandom_range(0, 'hFFFF)) - 'h8000);
            bus.seg_ay = CW'(int'($urandom_range(0, 'hFFFF)) - 'h8000);
            bus.seg_bx = ($urandom_range(0, 7) == 0) ? bus.seg_ax : CW'(int'($urandom_range(0, 'hFFFF)) - 'h8000);
            bus.seg_by = ($urandom_range(0, 7) == 0) ? bus.seg_ay : CW'(int'($urandom_range(0, 'hFFFF)) - 'h8000);
            s = int'($urandom_range(0, NS - 1));
            px = m_ax[s] + (m_bx[s] - m_ax[s]) * longint'($urandom_range(0, 20)) / 16;
            py = m_ay[s] + (m_by[s] - m_ay[s]) * longint'($urandom_range(0, 20)) / 16;
            if ($urandom_range(0, 1) == 0) py = m_ay[s] + (px - m_ax[s]) * (m_by[s] - m_ay[s]) / ((m_bx[s] == m_ax[s]) ? 1 : (m_bx[s] - m_ax[s]));
            if ($urandom_range(0, 3) != 0) begin
                px += longint'($urandom_range(0, 128)) - 64;
                py += longint'($urandom_range(0, 128)) - 64;
            end
            bus.pix_valid = ($urandom_range(0, 3) != 0);
            bus.h_cnt_Q = CW'(px);
            bus.v_cnt_Q = CW'(py);
            tick();
        end
        rst = 0; bus.seg_wr_en = 0; bus.pix_valid = 0; bus.frame_start = 0;
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
